issue_dispatcher: RTL and testbench

- Consumer end of the per-unit issue FIFO: pops the head entry in order once its source operands are ready, then presents it to one execution unit over a valid/ready handshake.
- Sits between the issue FIFO (show-ahead read: head data valid whenever not empty; pop on read_en) and the functional-unit input latch.
- Performs operand wakeup from the physical-register ready vector plus same-cycle CDB bypass.
- Keeps issue and stall performance counters.

---
 rtl/issue_dispatcher_if.sv | 51 +++++
 rtl/issue_dispatcher.sv | 100 ++++++++++
 tb/tb_issue_dispatcher.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_dispatcher_if.sv
// ============================================================================
//  Module      : issue_dispatcher_if
//  Description : Bundles the issue-FIFO head, wakeup sources (scoreboard and
//                CDB) and the execution-unit valid/ready handshake seen by
//                the issue dispatcher.
//                master : the dispatcher (pops the FIFO, drives ex_*)
//                slave  : the environment (FIFO, scoreboard, CDB, FU latch)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface issue_dispatcher_if #(
    parameter int DATA_W   = 128,
    parameter int NUM_PREG = 64,
    parameter int PREG_W   = $clog2(NUM_PREG)
);
    // Issue FIFO head (show-ahead)
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_rdata;
    logic [PREG_W-1:0]   fifo_ps1;
    logic [PREG_W-1:0]   fifo_ps2;
    logic                fifo_use1;
    logic                fifo_use2;
    logic                fifo_read_en;
    // Wakeup sources
    logic [NUM_PREG-1:0] preg_ready;
    logic                cdb_valid;
    logic [PREG_W-1:0]   cdb_tag;
    // Execution-unit handshake
    logic                ex_valid;
    logic                ex_ready;
    logic [DATA_W-1:0]   ex_data;

    modport master (
        input  fifo_empty, fifo_rdata, fifo_ps1, fifo_ps2, fifo_use1, fifo_use2,
        output fifo_read_en,
        input  preg_ready, cdb_valid, cdb_tag,
        output ex_valid, ex_data,
        input  ex_ready
    );

    modport slave (
        output fifo_empty, fifo_rdata, fifo_ps1, fifo_ps2, fifo_use1, fifo_use2,
        input  fifo_read_en,
        output preg_ready, cdb_valid, cdb_tag,
        input  ex_valid, ex_data,
        output ex_ready
    );
endinterface

`default_nettype wire

// File: rtl/issue_dispatcher.sv
// ============================================================================
//  Module      : issue_dispatcher
//  Description : In-order consumer of the per-unit issue FIFO. Pops the head
//                entry once both source operands are ready (scoreboard bit or
//                same-cycle CDB bypass) and presents it to one execution unit
//                through a single output register with valid/ready handshake.
//                Keeps issue and operand-stall performance counters.
//  Ports       : clk, rst_n (async, active low), flush (sync)
//                bus          - issue_dispatcher_if.master (FIFO head, wakeup,
//                               execution-unit handshake)
//                issue_count  - entries accepted by the execution unit
//                stall_count  - cycles the head was blocked on operands
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module issue_dispatcher #(
    parameter int DATA_W   = 128,
    parameter int NUM_PREG = 64,
    parameter int PREG_W   = $clog2(NUM_PREG),
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    issue_dispatcher_if.master   bus,
    output logic [CNT_W-1:0]     issue_count,
    output logic [CNT_W-1:0]     stall_count
);

    logic              w_src1_ready;
    logic              w_src2_ready;
    logic              w_head_ok;
    logic              w_slot_free;
    logic              w_pop;
    logic              w_transfer;
    logic              w_stall;

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_ex_data;
    logic [CNT_W-1:0]  r_issue_count;
    logic [CNT_W-1:0]  r_stall_count;

    // Tag 0 is the hard-wired always-ready register, so a CDB broadcast of
    // tag 0 can never change the outcome.
    assign w_src1_ready = !bus.fifo_use1
                        || (bus.fifo_ps1 == '0)
                        || bus.preg_ready[bus.fifo_ps1]
                        || (bus.cdb_valid && (bus.cdb_tag == bus.fifo_ps1));

    assign w_src2_ready = !bus.fifo_use2
                        || (bus.fifo_ps2 == '0)
                        || bus.preg_ready[bus.fifo_ps2]
                        || (bus.cdb_valid && (bus.cdb_tag == bus.fifo_ps2));

    assign w_head_ok   = !bus.fifo_empty && w_src1_ready && w_src2_ready;
    assign w_slot_free = !r_ex_valid || bus.ex_ready;
    assign w_transfer  = r_ex_valid && bus.ex_ready;
    assign w_stall     = !bus.fifo_empty && !(w_src1_ready && w_src2_ready) && !flush;

    // rst_n gates the pop so the FIFO is never drained while held in reset
    // (the output register is empty then, which would otherwise free the slot).
    assign w_pop = w_head_ok && w_slot_free && !flush && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_data     <= '0;
            r_issue_count <= '0;
            r_stall_count <= '0;
        end else begin
            // A transfer in the same cycle as a flush still completed at the
            // execution unit, so it is counted.
            if (w_transfer) begin
                r_issue_count <= r_issue_count + CNT_W'(1);
            end
            if (w_stall) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end

            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_pop) begin
                r_ex_valid <= 1'b1;
                r_ex_data  <= bus.fifo_rdata;
            end else if (w_transfer) begin
                r_ex_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_read_en = w_pop;
    assign bus.ex_valid     = r_ex_valid;
    assign bus.ex_data      = r_ex_data;
    assign issue_count      = r_issue_count;
    assign stall_count      = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_issue_dispatcher.sv
// ============================================================================
//  Module      : tb_issue_dispatcher
//  Description : Directed self-checking bench for issue_dispatcher.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_issue_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] issue_count;
    logic [31:0] stall_count;

    int vecs;
    int errs;

    issue_dispatcher_if bus ();

    issue_dispatcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .issue_count (issue_count),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n          = 1'b0;
        flush          = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        bus.fifo_ps1   = '0;
        bus.fifo_ps2   = '0;
        bus.fifo_use1  = 1'b0;
        bus.fifo_use2  = 1'b0;
        bus.preg_ready = '0;
        bus.cdb_valid  = 1'b0;
        bus.cdb_tag    = '0;
        bus.ex_ready   = 1'b0;
        #1;
        vecs++;
        if (bus.ex_valid !== 1'b0) begin
            errs++; $display("FAIL reset_ex_valid: got %b expected 0", bus.ex_valid);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vecs++;
            if (bus.fifo_read_en !== 1'b0) begin
                errs++; $display("FAIL empty_read_en[%0d]: got %b expected 0", i, bus.fifo_read_en);
            end
            vecs++;
            if (bus.ex_valid !== 1'b0) begin
                errs++; $display("FAIL empty_ex_valid[%0d]: got %b expected 0", i, bus.ex_valid);
            end
        end
        vecs++;
        if (bus.ex_data !== 128'h0) begin
            errs++; $display("FAIL reset_ex_data: got %h expected 0", bus.ex_data);
        end
        vecs++;
        if (issue_count !== 32'd0 || stall_count !== 32'd0) begin
            errs++; $display("FAIL reset_counters: got issue=%0d stall=%0d expected 0/0", issue_count, stall_count);
        end
    endtask

    task automatic test_operand_stall;
        logic [127:0] p;
        p = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        bus.fifo_empty = 1'b0;
        bus.fifo_rdata = p;
        bus.fifo_ps1   = 6'd5;
        bus.fifo_ps2   = 6'd0;
        bus.fifo_use1  = 1'b1;
        bus.fifo_use2  = 1'b1;
        bus.preg_ready = '0;
        bus.ex_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vecs++;
            if (bus.fifo_read_en !== 1'b0) begin
                errs++; $display("FAIL stall_read_en[%0d]: got %b expected 0", i, bus.fifo_read_en);
            end
            tick();
        end
        vecs++;
        if (stall_count !== 32'd3) begin
            errs++; $display("FAIL stall_count_3: got %0d expected 3", stall_count);
        end
        bus.preg_ready[5] = 1'b1;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b1) begin
            errs++; $display("FAIL wake_read_en: got %b expected 1", bus.fifo_read_en);
        end
        tick();
        bus.fifo_empty = 1'b1;
        #1;
        vecs++;
        if (bus.ex_valid !== 1'b1 || bus.ex_data !== p) begin
            errs++; $display("FAIL wake_ex_out: got v=%b d=%h expected v=1 d=%h", bus.ex_valid, bus.ex_data, p);
        end
        vecs++;
        if (stall_count !== 32'd3) begin
            errs++; $display("FAIL stall_count_hold: got %0d expected 3", stall_count);
        end
        tick();
        vecs++;
        if (bus.ex_valid !== 1'b0 || issue_count !== 32'd1) begin
            errs++; $display("FAIL wake_drain: got v=%b issue=%0d expected v=0 issue=1", bus.ex_valid, issue_count);
        end
    endtask

    task automatic test_cdb_bypass;
        logic [127:0] p;
        p = 128'hcafe_0000_1111_2222_3333_4444_5555_beef;
        bus.fifo_empty = 1'b0;
        bus.fifo_rdata = p;
        bus.fifo_ps1   = 6'd9;
        bus.fifo_ps2   = 6'd3;
        bus.fifo_use1  = 1'b1;
        bus.fifo_use2  = 1'b0;
        bus.preg_ready = '0;
        bus.cdb_valid  = 1'b0;
        bus.ex_ready   = 1'b1;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b0) begin
            errs++; $display("FAIL cdb_none_read_en: got %b expected 0", bus.fifo_read_en);
        end
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd8;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b0) begin
            errs++; $display("FAIL cdb_miss_read_en: got %b expected 0", bus.fifo_read_en);
        end
        bus.cdb_tag = 6'd9;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b1) begin
            errs++; $display("FAIL cdb_hit_read_en: got %b expected 1", bus.fifo_read_en);
        end
        tick();
        bus.fifo_empty = 1'b1;
        bus.cdb_valid  = 1'b0;
        #1;
        vecs++;
        if (bus.ex_valid !== 1'b1 || bus.ex_data !== p) begin
            errs++; $display("FAIL cdb_ex_out: got v=%b d=%h expected v=1 d=%h", bus.ex_valid, bus.ex_data, p);
        end
        vecs++;
        if (stall_count !== 32'd3) begin
            errs++; $display("FAIL cdb_stall_count: got %0d expected 3", stall_count);
        end
        tick();
        vecs++;
        if (bus.ex_valid !== 1'b0 || issue_count !== 32'd2) begin
            errs++; $display("FAIL cdb_drain: got v=%b issue=%0d expected v=0 issue=2", bus.ex_valid, issue_count);
        end
    endtask

    task automatic test_wakeup_boundaries;
        bus.ex_ready   = 1'b1;
        bus.preg_ready = '0;
        bus.fifo_empty = 1'b0;
        bus.fifo_ps1   = 6'd12;
        bus.fifo_ps2   = 6'd12;
        bus.fifo_use1  = 1'b1;
        bus.fifo_use2  = 1'b1;
        bus.cdb_valid  = 1'b1;
        bus.cdb_tag    = 6'd12;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b1) begin
            errs++; $display("FAIL cdb_both_src: got %b expected 1", bus.fifo_read_en);
        end
        bus.fifo_empty = 1'b1;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b0) begin
            errs++; $display("FAIL empty_blocks_pop: got %b expected 0", bus.fifo_read_en);
        end
        bus.fifo_empty = 1'b0;
        bus.fifo_ps1   = 6'd0;
        bus.fifo_ps2   = 6'd0;
        bus.cdb_valid  = 1'b0;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b1) begin
            errs++; $display("FAIL tag0_ready: got %b expected 1", bus.fifo_read_en);
        end
        bus.fifo_ps1  = 6'd7;
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 6'd0;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b0) begin
            errs++; $display("FAIL cdb_tag0_no_wake: got %b expected 0", bus.fifo_read_en);
        end
        bus.fifo_empty = 1'b1;
        bus.cdb_valid  = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [127:0] d [4];
        bit   rdy    [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit   exp_rd [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bit   exp_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   exp_di [7] = '{0, 0, 0, 1, 2, 3, 0};
        int   idx;
        int   nx;
        logic popped;
        d[0] = 128'h1000_0000_0000_0000_0000_0000_0000_00a0;
        d[1] = 128'h2000_0000_0000_0000_0000_0000_0000_00b1;
        d[2] = 128'h3000_0000_0000_0000_0000_0000_0000_00c2;
        d[3] = 128'h4000_0000_0000_0000_0000_0000_0000_00d3;
        idx = 0;
        nx  = 0;
        bus.fifo_use1 = 1'b0;
        bus.fifo_use2 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            bus.ex_ready   = rdy[c];
            bus.fifo_empty = (idx >= 4);
            bus.fifo_rdata = (idx < 4) ? d[idx] : '0;
            #1;
            vecs++;
            if (bus.fifo_read_en !== exp_rd[c]) begin
                errs++; $display("FAIL b2b_read_en[%0d]: got %b expected %b", c, bus.fifo_read_en, exp_rd[c]);
            end
            if (bus.ex_valid === 1'b1 && bus.ex_ready === 1'b1) begin
                vecs++;
                if (nx > 3 || bus.ex_data !== d[nx & 3]) begin
                    errs++; $display("FAIL b2b_order[%0d]: got %h expected %h", nx, bus.ex_data, d[nx & 3]);
                end
                nx++;
            end
            popped = bus.fifo_read_en;
            tick();
            if (popped === 1'b1) idx++;
            vecs++;
            if (bus.ex_valid !== exp_v[c]) begin
                errs++; $display("FAIL b2b_ex_valid[%0d]: got %b expected %b", c, bus.ex_valid, exp_v[c]);
            end
            if (exp_v[c]) begin
                vecs++;
                if (bus.ex_data !== d[exp_di[c]]) begin
                    errs++; $display("FAIL b2b_ex_data[%0d]: got %h expected %h", c, bus.ex_data, d[exp_di[c]]);
                end
            end
        end
        vecs++;
        if (nx !== 4 || issue_count !== 32'd6) begin
            errs++; $display("FAIL b2b_delivered: got n=%0d issue=%0d expected n=4 issue=6", nx, issue_count);
        end
        bus.fifo_empty = 1'b1;
    endtask

    task automatic test_flush;
        logic [127:0] e0;
        logic [127:0] e1;
        e0 = 128'h0e0e_0e0e_0e0e_0e0e_0e0e_0e0e_0e0e_0e0e;
        e1 = 128'h1e1e_1e1e_1e1e_1e1e_1e1e_1e1e_1e1e_1e1e;
        bus.fifo_use1  = 1'b0;
        bus.fifo_use2  = 1'b0;
        bus.fifo_empty = 1'b0;
        bus.fifo_rdata = e0;
        bus.ex_ready   = 1'b0;
        flush          = 1'b0;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b1) begin
            errs++; $display("FAIL flush_load_read_en: got %b expected 1", bus.fifo_read_en);
        end
        tick();
        bus.fifo_rdata = e1;
        vecs++;
        if (bus.ex_valid !== 1'b1 || bus.ex_data !== e0) begin
            errs++; $display("FAIL flush_loaded: got v=%b d=%h expected v=1 d=%h", bus.ex_valid, bus.ex_data, e0);
        end
        flush = 1'b1;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b0) begin
            errs++; $display("FAIL flush_no_pop: got %b expected 0", bus.fifo_read_en);
        end
        tick();
        vecs++;
        if (bus.ex_valid !== 1'b0 || bus.ex_data !== e0) begin
            errs++; $display("FAIL flush_clears_valid: got v=%b d=%h expected v=0 d=%h", bus.ex_valid, bus.ex_data, e0);
        end
        flush = 1'b0;
        #1;
        vecs++;
        if (bus.fifo_read_en !== 1'b1) begin
            errs++; $display("FAIL flush_resume_pop: got %b expected 1", bus.fifo_read_en);
        end
        tick();
        bus.fifo_empty = 1'b1;
        vecs++;
        if (bus.ex_valid !== 1'b1 || bus.ex_data !== e1 || issue_count !== 32'd6) begin
            errs++; $display("FAIL flush_resumed: got v=%b d=%h issue=%0d expected v=1 d=%h issue=6", bus.ex_valid, bus.ex_data, issue_count, e1);
        end
        bus.ex_ready = 1'b1;
        flush        = 1'b1;
        tick();
        vecs++;
        if (bus.ex_valid !== 1'b0 || issue_count !== 32'd7) begin
            errs++; $display("FAIL flush_xfer_counted: got v=%b issue=%0d expected v=0 issue=7", bus.ex_valid, issue_count);
        end
        bus.fifo_empty = 1'b0;
        bus.fifo_use1  = 1'b1;
        bus.fifo_ps1   = 6'd20;
        bus.preg_ready = '0;
        bus.cdb_valid  = 1'b0;
        tick();
        vecs++;
        if (stall_count !== 32'd3) begin
            errs++; $display("FAIL flush_no_stall: got %0d expected 3", stall_count);
        end
        flush = 1'b0;
        tick();
        vecs++;
        if (stall_count !== 32'd4) begin
            errs++; $display("FAIL stall_after_flush: got %0d expected 4", stall_count);
        end
        bus.fifo_empty = 1'b1;
        bus.fifo_use1  = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        logic [127:0] f;
        f = 128'hf00d_f00d_f00d_f00d_f00d_f00d_f00d_f00d;
        bus.fifo_empty = 1'b0;
        bus.fifo_rdata = f;
        bus.ex_ready   = 1'b0;
        tick();
        vecs++;
        if (bus.ex_valid !== 1'b1 || bus.ex_data !== f || issue_count !== 32'd7 || stall_count !== 32'd4) begin
            errs++; $display("FAIL pre_reset_state: got v=%b d=%h issue=%0d stall=%0d expected v=1 d=%h issue=7 stall=4", bus.ex_valid, bus.ex_data, issue_count, stall_count, f);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.ex_valid !== 1'b0 || bus.ex_data !== 128'h0) begin
            errs++; $display("FAIL async_reset_out: got v=%b d=%h expected v=0 d=0", bus.ex_valid, bus.ex_data);
        end
        vecs++;
        if (issue_count !== 32'd0 || stall_count !== 32'd0) begin
            errs++; $display("FAIL async_reset_counters: got issue=%0d stall=%0d expected 0/0", issue_count, stall_count);
        end
        vecs++;
        if (bus.fifo_read_en !== 1'b0) begin
            errs++; $display("FAIL reset_read_en: got %b expected 0", bus.fifo_read_en);
        end
        tick();
        vecs++;
        if (bus.ex_valid !== 1'b0) begin
            errs++; $display("FAIL held_reset_ex_valid: got %b expected 0", bus.ex_valid);
        end
        bus.fifo_empty = 1'b1;
        rst_n          = 1'b1;
        tick();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_operand_stall();
        test_cdb_bypass();
        test_wakeup_boundaries();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
